// File: rtl/major_1_pkg.sv
// Shared constants, config-word field layout and controller state encoding
// for the major_1 vending controller.
package major_1_pkg;

   localparam int ITEMS     = 64;
   localparam int ITEMSIZE  = 6;
   localparam int PRICE_LSB = 0;
   localparam int PRICE_W   = 16;
   localparam int STOCK_LSB = 16;
   localparam int STOCK_W   = 7;
   localparam int ENTRY_W   = PRICE_W + STOCK_W;
   localparam int CREDIT_W  = 17;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2
   } state_t;

endpackage

// File: rtl/major_1_item_table.sv
// Per-slot price/stock table: config write and registered read port, a
// combinational lookup port for selection, and a stock decrement port.
module major_1_item_table
   import major_1_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ITEMSIZE-1:0] wr_addr,
   input  logic [ENTRY_W-1:0]  wr_data,
   input  logic                rd_en,
   input  logic [ITEMSIZE-1:0] rd_addr,
   output logic [31:0]         rd_data,
   input  logic [ITEMSIZE-1:0] lk_addr,
   output logic [PRICE_W-1:0]  lk_price,
   output logic [STOCK_W-1:0]  lk_stock,
   input  logic                dec_en,
   input  logic [ITEMSIZE-1:0] dec_addr
);

   logic [PRICE_W-1:0] price [ITEMS];
   logic [STOCK_W-1:0] stock [ITEMS];

   // NOTE: the table must clear on reset, so it is built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ITEMS; i++) begin
            price[i] <= '0;
            stock[i] <= '0;
         end
      end else begin
         // Write is issued last so a same-slot config write overrides the decrement.
         if (dec_en && stock[dec_addr] != '0)
            stock[dec_addr] <= stock[dec_addr] - 1'b1;
         if (wr_en) begin
            price[wr_addr] <= wr_data[PRICE_LSB +: PRICE_W];
            stock[wr_addr] <= wr_data[STOCK_LSB +: STOCK_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= {{(32-ENTRY_W){1'b0}}, stock[rd_addr], price[rd_addr]};
   end

   assign lk_price = price[lk_addr];
   assign lk_stock = stock[lk_addr];

endmodule

// File: rtl/major_1.sv
// Vending controller top: selection/credit FSM with registered dispense
// outputs, plus the APB-style config port into the item table.
module major_1
   import major_1_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         paddr,
   input  logic                pwrite,
   input  logic                psel,
   input  logic [31:0]         pwdata,
   output logic [31:0]         prdata,
   input  logic                i_valid,
   input  logic [6:0]          note_val,
   input  logic                item_valid,
   input  logic [ITEMSIZE-1:0] item_code,
   output logic                o_valid,
   output logic [ITEMSIZE-1:0] output_item,
   output logic [15:0]         note_change
);

   state_t                state_q, state_d;
   logic [ITEMSIZE-1:0]   code_q, code_d;
   logic [PRICE_W-1:0]    price_q, price_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d, credit_sum;
   logic                  valid_d;
   logic [ITEMSIZE-1:0]   item_d;
   logic [15:0]           change_d;
   logic                  dec_en;
   logic [PRICE_W-1:0]    lk_price;
   logic [STOCK_W-1:0]    lk_stock;
   logic                  unused_bits;

   assign unused_bits = ^{paddr[31:ITEMSIZE], pwdata[31:ENTRY_W]};

   major_1_item_table u_table (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (psel & pwrite),
      .wr_addr  (paddr[ITEMSIZE-1:0]),
      .wr_data  (pwdata[ENTRY_W-1:0]),
      .rd_en    (psel & ~pwrite),
      .rd_addr  (paddr[ITEMSIZE-1:0]),
      .rd_data  (prdata),
      .lk_addr  (item_code),
      .lk_price (lk_price),
      .lk_stock (lk_stock),
      .dec_en   (dec_en),
      .dec_addr (code_q)
   );

   assign credit_sum = credit_q + CREDIT_W'(note_val);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      price_d  = price_q;
      credit_d = credit_q;
      valid_d  = 1'b0;
      item_d   = '0;
      change_d = '0;
      dec_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (item_valid) begin
               code_d   = item_code;
               price_d  = lk_price;
               credit_d = '0;
               if (lk_stock != '0 && lk_price != '0)
                  state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (i_valid) begin
               credit_d = credit_sum;
               if (credit_sum >= {1'b0, price_q}) begin
                  state_d  = DISPENSE;
                  valid_d  = 1'b1;
                  item_d   = code_q;
                  change_d = credit_sum[15:0] - price_q;
               end
            end
         end
         DISPENSE: begin
            dec_en   = 1'b1;
            credit_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         code_q      <= '0;
         price_q     <= '0;
         credit_q    <= '0;
         o_valid     <= 1'b0;
         output_item <= '0;
         note_change <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         price_q     <= price_d;
         credit_q    <= credit_d;
         o_valid     <= valid_d;
         output_item <= item_d;
         note_change <= change_d;
      end
   end

endmodule

// File: tb/tb_major_1.sv
// Scoreboard bench for major_1: a transaction-level vending model predicts
// dispenses and read data; a monitor compares whenever the DUT responds.
module tb_major_1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic        psel = 1'b0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        i_valid = 1'b0;
   logic [6:0]  note_val = '0;
   logic        item_valid = 1'b0;
   logic [5:0]  item_code = '0;
   logic        o_valid;
   logic [5:0]  output_item;
   logic [15:0] note_change;

   int checks = 0;
   int failures = 0;

   major_1 dut (
      .clk         (clk),
      .rst         (rst),
      .paddr       (paddr),
      .pwrite      (pwrite),
      .psel        (psel),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .i_valid     (i_valid),
      .note_val    (note_val),
      .item_valid  (item_valid),
      .item_code   (item_code),
      .o_valid     (o_valid),
      .output_item (output_item),
      .note_change (note_change)
   );

   always #5 clk = ~clk;

   // Reference model: table contents and the customer session.
   logic [15:0] m_price [64];
   logic [6:0]  m_stock [64];
   int          m_phase = 0;   // 0 waiting for selection, 1 paying, 2 dispensing
   int          m_credit = 0;
   int          m_lprice = 0;
   logic [5:0]  m_lcode = '0;

   logic [21:0] exp_q [$];
   logic [31:0] rd_q [$];
   logic        rd_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         m_price[i] = '0;
         m_stock[i] = '0;
      end
      m_phase = 0;
      m_credit = 0;
      exp_q.delete();
      rd_q.delete();
   endtask

   // One clock of stimulus; the model is advanced with the same inputs.
   task automatic cyc(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit sel, input logic [5:0] code, input bit ins, input logic [6:0] val);
      logic [5:0] a;
      bit         dec_now;
      a = addr[5:0];
      dec_now = 1'b0;
      psel = wr | rd;
      pwrite = wr;
      paddr = addr;
      pwdata = wdata;
      item_valid = sel;
      item_code = code;
      i_valid = ins;
      note_val = val;
      if (rd && !wr)
         rd_q.push_back({9'b0, m_stock[a], m_price[a]});
      case (m_phase)
         0: if (sel && m_stock[code] != 0 && m_price[code] != 0) begin
               m_phase = 1;
               m_lprice = int'(m_price[code]);
               m_lcode = code;
               m_credit = 0;
            end
         1: if (ins) begin
               m_credit += int'(val);
               if (m_credit >= m_lprice) begin
                  exp_q.push_back({m_lcode, 16'(m_credit - m_lprice)});
                  m_phase = 2;
               end
            end
         default: begin
            m_phase = 0;
            dec_now = 1'b1;
         end
      endcase
      if (dec_now && !(wr && a == m_lcode) && m_stock[m_lcode] != 0)
         m_stock[m_lcode] = m_stock[m_lcode] - 7'd1;
      if (wr) begin
         m_price[a] = wdata[15:0];
         m_stock[a] = wdata[22:16];
      end
      @(posedge clk);
      @(negedge clk);
      psel = 1'b0;
      pwrite = 1'b0;
      item_valid = 1'b0;
      i_valid = 1'b0;
   endtask

   task automatic wr_slot(input logic [31:0] addr, input logic [31:0] data);
      cyc(1, 0, addr, data, 0, 0, 0, 0);
   endtask
   task automatic rd_slot(input logic [31:0] addr);
      cyc(0, 1, addr, 0, 0, 0, 0, 0);
   endtask
   task automatic sel_item(input logic [5:0] code);
      cyc(0, 0, 0, 0, 1, code, 0, 0);
   endtask
   task automatic note(input logic [6:0] val);
      cyc(0, 0, 0, 0, 0, 0, 1, val);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: reads complete one edge after the request; dispenses pop the scoreboard.
   always @(posedge clk) rd_seen <= psel && !pwrite && !rst;

   always @(negedge clk) begin
      if (!rst) begin
         if (rd_seen) begin
            if (rd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_unexpected: prdata 0x%08h with no read expected", prdata);
            end else begin
               check("prdata", prdata, rd_q.pop_front());
            end
         end
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_dispense: item %0d change %0d, none expected at %0t",
                        output_item, note_change, $time);
            end else begin
               logic [21:0] e;
               e = exp_q.pop_front();
               check("output_item", 32'(output_item), 32'(e[21:16]));
               check("note_change", 32'(note_change), 32'(e[15:0]));
            end
         end else begin
            check("idle_outputs_zero", {10'b0, output_item, note_change}, 32'h0);
         end
      end
   end

   initial begin
      model_clear();
      #1;
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_output_item", 32'(output_item), 0);
      check("rst_note_change", 32'(note_change), 0);
      check("rst_prdata", prdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Config round-trip
      wr_slot(32'h0, 32'h0064_0096);
      wr_slot(32'h1, 32'h0064_0064);
      rd_slot(32'h0);
      rd_slot(32'hABCD_0001);

      // Exact pay, then stock decrement visible
      sel_item(6'd1);
      note(7'd100);
      idle();
      rd_slot(32'h1);

      // Overpay over two notes
      sel_item(6'd0);
      note(7'd100);
      note(7'd100);
      idle();

      // Out of stock, then a normal purchase
      wr_slot(32'h2, 32'h0000_0014);
      sel_item(6'd2);
      note(7'd50);
      sel_item(6'd1);
      note(7'd100);
      idle();

      // Notes in IDLE ignored; selection locked during COLLECT
      note(7'd100);
      sel_item(6'd1);
      sel_item(6'd0);
      note(7'd100);
      idle();

      // Config write in the decrement cycle wins
      sel_item(6'd1);
      note(7'd100);
      wr_slot(32'h1, 32'h0032_0064);
      rd_slot(32'h1);

      // Price change during COLLECT does not affect the latched price; zero note adds nothing
      sel_item(6'd0);
      wr_slot(32'h0, 32'h0064_000A);
      note(7'd0);
      note(7'd100);
      note(7'd60);
      idle();
      rd_slot(32'h0);

      // Async reset mid-COLLECT
      sel_item(6'd1);
      note(7'd50);
      #2 rst = 1'b1;
      #1;
      check("midrst_o_valid", 32'(o_valid), 0);
      check("midrst_output_item", 32'(output_item), 0);
      check("midrst_note_change", 32'(note_change), 0);
      check("midrst_prdata", prdata, 0);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_slot(32'h0);
      rd_slot(32'h1);
      note(7'd100);
      idle();
      idle();

      // Randomized traffic over a small slot range to force collisions
      for (int s = 0; s < 8; s++)
         wr_slot(32'(s), 32'h0003_0000 | 32'($urandom_range(1, 200)));
      for (int n = 0; n < 4000; n++) begin
         int          r;
         logic [31:0] addr;
         logic [31:0] wdata;
         logic [15:0] pr;
         r = $urandom_range(0, 9);
         addr = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
         pr = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
         wdata = ($urandom & 32'hFF80_0000) | (32'($urandom_range(0, 4)) << 16) | 32'(pr);
         cyc(r == 0, r == 1, addr, wdata, $urandom_range(0, 3) == 0, 6'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, 7'($urandom_range(0, 127)));
      end
      idle();
      idle();
      check("pending_dispense", 32'(exp_q.size()), 0);
      check("pending_reads", 32'(rd_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
